// File: rtl/mips_stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks each instruction through NUM_STAGES stages and
// resolves the next PC (end/jump/branch/sequential) on the last-stage advance edge.
module mips_stage_sequencer #(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned PROG_DEPTH = 256,
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch,
  input  logic                  zero,
  input  logic [PC_WIDTH-1:0]   branch_offset,
  input  logic                  jump,
  input  logic [PC_WIDTH-1:0]   jump_target,
  input  logic                  end_program,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [2:0]            stage,
  output logic [NUM_STAGES-1:0] stage_onehot,
  output logic                  retire,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic                  halted,
  output logic                  addr_fault
);

  localparam logic [2:0]          LastStage = 3'(NUM_STAGES - 1);
  localparam logic [PC_WIDTH-1:0] LastPc    = PC_WIDTH'(PROG_DEPTH - 1);
  localparam logic [PC_WIDTH-1:0] ResetPc   = PC_WIDTH'(RESET_PC);
  // One extra bit so PROG_DEPTH == 2^PC_WIDTH is representable.
  localparam logic [PC_WIDTH:0]   DepthExt  = (PC_WIDTH + 1)'(PROG_DEPTH);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e                state_q, state_d;
  logic [2:0]            stage_q, stage_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  retire_q, retire_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  fault_q, fault_d;

  logic                  taken;
  logic [PC_WIDTH-1:0]   target;
  logic                  target_bad;
  logic [PC_WIDTH-1:0]   pc_seq;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StRun;
      stage_q  <= '0;
      pc_q     <= ResetPc;
      retire_q <= 1'b0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    taken      = jump | (branch & zero);
    target     = jump ? jump_target : pc_q + PC_WIDTH'(1) + branch_offset;
    target_bad = {1'b0, target} >= DepthExt;
    pc_seq     = (pc_q == LastPc) ? '0 : pc_q + PC_WIDTH'(1);

    state_d  = state_q;
    stage_d  = stage_q;
    pc_d     = pc_q;
    retire_d = 1'b0;
    cnt_d    = cnt_q;
    fault_d  = fault_q;

    if (state_q == StRun && !stall) begin
      if (stage_q == LastStage) begin
        // Advance edge: the only time control inputs are looked at.
        stage_d  = '0;
        retire_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (end_program) begin
          state_d = StHalt;
        end else if (taken) begin
          if (target_bad) begin
            state_d = StHalt;
            fault_d = 1'b1;
          end else begin
            pc_d = target;
          end
        end else begin
          pc_d = pc_seq;
        end
      end else begin
        stage_d = stage_q + 3'd1;
      end
    end
  end

  always_comb begin
    pc           = pc_q;
    stage        = stage_q;
    retire       = retire_q;
    instr_count  = cnt_q;
    halted       = (state_q == StHalt);
    addr_fault   = fault_q;
    stage_onehot = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      stage_onehot[i] = (state_q == StRun) && (stage_q == 3'(i));
    end
  end

endmodule

// File: tb/tb_mips_stage_sequencer.sv
// Directed bench for mips_stage_sequencer (PC_WIDTH=4, PROG_DEPTH=9, NUM_STAGES=5); a second
// instance with a 3-bit counter shares the stimulus to exercise counter saturation.
module tb_mips_stage_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic       branch = 1'b0;
  logic       zero = 1'b0;
  logic [3:0] branch_offset = '0;
  logic       jump = 1'b0;
  logic [3:0] jump_target = '0;
  logic       end_program = 1'b0;

  logic [3:0]  pc;
  logic [2:0]  stage;
  logic [4:0]  stage_onehot;
  logic        retire;
  logic [15:0] instr_count;
  logic        halted;
  logic        addr_fault;

  logic [3:0]  s_pc;
  logic [2:0]  s_stage;
  logic [4:0]  s_onehot;
  logic        s_retire;
  logic [2:0]  s_count;
  logic        s_halted;
  logic        s_fault;

  int vecs = 0;
  int miss = 0;

  always #5 clock = ~clock;

  mips_stage_sequencer #(
    .PC_WIDTH(4), .PROG_DEPTH(9), .NUM_STAGES(5), .RESET_PC(0), .CNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch(branch), .zero(zero),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .end_program(end_program), .pc(pc), .stage(stage), .stage_onehot(stage_onehot),
    .retire(retire), .instr_count(instr_count), .halted(halted), .addr_fault(addr_fault)
  );

  mips_stage_sequencer #(
    .PC_WIDTH(4), .PROG_DEPTH(9), .NUM_STAGES(5), .RESET_PC(0), .CNT_WIDTH(3)
  ) dut_sat (
    .clock(clock), .reset(reset), .stall(stall), .branch(branch), .zero(zero),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .end_program(end_program), .pc(s_pc), .stage(s_stage), .stage_onehot(s_onehot),
    .retire(s_retire), .instr_count(s_count), .halted(s_halted), .addr_fault(s_fault)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Navigate to the last stage of instruction p; bounded so a broken PC cannot hang the run.
  task automatic goto_last(input logic [3:0] p);
    int n;
    n = 0;
    while (!(pc === p && stage === 3'd4) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      vecs++;
      miss++;
      $error("FAIL goto_pc%0d: observed pc %0d stage %0d expected pc %0d stage 4",
             p, pc, stage, p);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_stage"}, 32'(stage), 32'd0);
    chk({tag, "_onehot"}, 32'(stage_onehot), 32'd1);
    chk({tag, "_retire"}, 32'(retire), 32'd0);
    chk({tag, "_count"}, 32'(instr_count), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_fault"}, 32'(addr_fault), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_reset_state("rst");
    reset = 1'b1;

    // Sequential run: 50 cycles
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("seq_stage", 32'(stage), 32'(k % 5));
      chk("seq_pc", 32'(pc), 32'((k / 5) % 9));
      chk("seq_retire", 32'(retire), 32'(k % 5 == 0));
      chk("seq_onehot", 32'(stage_onehot), 32'(1 << (k % 5)));
    end
    chk("seq_count", 32'(instr_count), 32'd10);

    // Control inputs away from the advance edge are ignored
    goto_last(4'd2);
    tick();
    jump = 1'b1; jump_target = 4'd7; end_program = 1'b1;
    tick(); tick(); tick();
    chk("ign_stage", 32'(stage), 32'd3);
    chk("ign_pc", 32'(pc), 32'd3);
    jump = 1'b0; jump_target = '0; end_program = 1'b0;

    // Taken branch at pc 3, offset 2 -> 6
    goto_last(4'd3);
    branch = 1'b1; zero = 1'b1; branch_offset = 4'd2;
    tick();
    branch = 1'b0; zero = 1'b0; branch_offset = '0;
    chk("br_taken_pc", 32'(pc), 32'd6);
    chk("br_taken_stage", 32'(stage), 32'd0);
    chk("br_taken_retire", 32'(retire), 32'd1);

    // Not taken -> sequential
    goto_last(4'd3);
    branch = 1'b1; zero = 1'b0; branch_offset = 4'd2;
    tick();
    branch = 1'b0; branch_offset = '0;
    chk("br_nt_pc", 32'(pc), 32'd4);

    // Negative offset: 3 + 1 - 4 = 0
    goto_last(4'd3);
    branch = 1'b1; zero = 1'b1; branch_offset = 4'b1100;
    tick();
    branch = 1'b0; zero = 1'b0; branch_offset = '0;
    chk("br_neg_pc", 32'(pc), 32'd0);

    // Jump beats branch
    goto_last(4'd1);
    jump = 1'b1; jump_target = 4'd7; branch = 1'b1; zero = 1'b1; branch_offset = 4'd2;
    tick();
    jump = 1'b0; jump_target = '0; branch = 1'b0; zero = 1'b0; branch_offset = '0;
    chk("jmp_pc", 32'(pc), 32'd7);
    chk("jmp_halted", 32'(halted), 32'd0);

    // Out-of-range jump target
    goto_last(4'd7);
    jump = 1'b1; jump_target = 4'd12;
    tick();
    jump = 1'b0; jump_target = '0;
    chk("jbad_halted", 32'(halted), 32'd1);
    chk("jbad_fault", 32'(addr_fault), 32'd1);
    chk("jbad_pc", 32'(pc), 32'd7);
    chk("jbad_onehot", 32'(stage_onehot), 32'd0);

    // Reset out of a faulted halt
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_reset_state("rst_halt");

    // Stall at stage 2 for 3 cycles
    tick(); tick();
    chk("stl_pre", 32'(stage), 32'd2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stl_s2", 32'(stage), 32'd2);
    end
    stall = 1'b0;
    tick();
    chk("stl_resume", 32'(stage), 32'd3);

    // Stall at stage 4 delays retire
    tick();
    chk("stl4_stage", 32'(stage), 32'd4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stl4_retire", 32'(retire), 32'd0);
      chk("stl4_stage_hold", 32'(stage), 32'd4);
      chk("stl4_count", 32'(instr_count), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("stl4_retire_late", 32'(retire), 32'd1);
    chk("stl4_pc", 32'(pc), 32'd1);
    chk("stl4_count_late", 32'(instr_count), 32'd1);

    // end_program at pc 5: pcs 0..5 retired
    goto_last(4'd5);
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    chk("end_retire", 32'(retire), 32'd1);
    chk("end_halted", 32'(halted), 32'd1);
    chk("end_pc", 32'(pc), 32'd5);
    chk("end_count", 32'(instr_count), 32'd6);
    chk("end_fault", 32'(addr_fault), 32'd0);
    for (int k = 0; k < 20; k++) begin
      stall = k[0]; jump = 1'b1; jump_target = 4'd2; branch = 1'b1; zero = 1'b1;
      end_program = k[1];
      tick();
      chk("halt_pc", 32'(pc), 32'd5);
      chk("halt_stage", 32'(stage), 32'd0);
      chk("halt_onehot", 32'(stage_onehot), 32'd0);
      chk("halt_count", 32'(instr_count), 32'd6);
      chk("halt_halted", 32'(halted), 32'd1);
    end
    stall = 1'b0; jump = 1'b0; jump_target = '0; branch = 1'b0; zero = 1'b0;
    end_program = 1'b0;

    // Leave halt, then reset mid-instruction at stage 3
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_reset_state("rst_end");
    goto_last(4'd2);
    tick(); tick(); tick(); tick();
    chk("mid_stage", 32'(stage), 32'd3);
    chk("mid_pc", 32'(pc), 32'd3);
    reset = 1'b0; stall = 1'b1; jump = 1'b1; jump_target = 4'd6;
    tick();
    reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0;
    chk_reset_state("rst_mid");

    // Saturation: 10 instructions on the 3-bit counter instance
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("sat_retire", 32'(s_retire), 32'(k % 5 == 0));
      chk("sat_count", 32'(s_count), 32'((k / 5) > 7 ? 7 : (k / 5)));
    end
    chk("sat_wide_count", 32'(instr_count), 32'd10);
    chk("sat_halted", 32'(s_halted), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/mips_stage_sequencer.md
MIPS_STAGE_SEQUENCER -- requirements
Module: mips_stage_sequencer

Interface
REQ-001 SHALL provide parameter PC_WIDTH, default 8, width of the instruction index.
REQ-002 SHALL provide parameter PROG_DEPTH, default 256, number of valid instruction slots; legal range 2..2^PC_WIDTH.
REQ-003 SHALL provide parameter NUM_STAGES, default 5, number of stages per instruction; legal range 2..8.
REQ-004 SHALL provide parameter RESET_PC, default 0, PC after reset; must be < PROG_DEPTH.
REQ-005 SHALL provide parameter CNT_WIDTH, default 16, width of the retired-instruction counter.
REQ-006 clock  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 stall  input  1  1 = hold current stage and PC this cycle.
REQ-009 branch  input  1  current instruction is a conditional branch.
REQ-010 zero  input  1  ALU zero flag; branch taken when branch=1 and zero=1.
REQ-011 branch_offset  input  PC_WIDTH  two's-complement offset relative to pc+1.
REQ-012 jump  input  1  current instruction is an unconditional jump.
REQ-013 jump_target  input  PC_WIDTH  absolute jump index.
REQ-014 end_program  input  1  current instruction terminates the program.
REQ-015 pc  output  PC_WIDTH  index of the instruction in flight.
REQ-016 stage  output  3  current stage number, 0..NUM_STAGES-1.
REQ-017 stage_onehot  output  NUM_STAGES  bit[stage]=1 while running, all-zero when halted.
REQ-018 retire  output  1  one-cycle pulse when an instruction completes its last stage.
REQ-019 instr_count  output  CNT_WIDTH  number of retired instructions, saturating.
REQ-020 halted  output  1  sticky; sequencer stopped.
REQ-021 addr_fault  output  1  sticky; halt caused by an out-of-range branch/jump target.

Function
REQ-022 SHALL implement two states, RUN and HALT; reset enters RUN.
REQ-023 In RUN with stall=0, stage SHALL advance by 1 per cycle, wrapping from NUM_STAGES-1 to 0.
REQ-024 In RUN with stall=1, stage, pc, and instr_count SHALL hold; retire SHALL be 0.
REQ-025 branch, zero, branch_offset, jump, jump_target, and end_program SHALL be sampled only on the advance edge: stage=NUM_STAGES-1, stall=0, state RUN. They are ignored at all other times.
REQ-026 On the advance edge, retire SHALL be 1 for the following cycle, and instr_count SHALL increment, saturating at 2^CNT_WIDTH-1.
REQ-027 Next-PC priority on the advance edge: end_program, then jump, then taken branch, then sequential.
REQ-028 end_program=1: pc SHALL hold, stage SHALL go to 0, state SHALL go to HALT, and halted SHALL go to 1. The instruction still retires.
REQ-029 jump=1: the target is jump_target.
REQ-030 Taken branch: the target is (pc + 1 + branch_offset) mod 2^PC_WIDTH.
REQ-031 If the jump or branch target is >= PROG_DEPTH: pc SHALL hold, and the block SHALL enter HALT with halted=1 and addr_fault=1.
REQ-032 Sequential: pc SHALL become pc+1, or 0 when pc = PROG_DEPTH-1.
REQ-033 branch=1 with zero=0 SHALL be treated as sequential.
REQ-034 In HALT, all outputs SHALL hold and all inputs SHALL be ignored; only reset leaves HALT.
REQ-035 New pc SHALL be visible in the same cycle that stage becomes 0.
REQ-036 The pc output SHALL be registered, and all other outputs SHALL be registered or decoded from registers only; no combinational path from inputs to outputs.

Reset
REQ-037 When reset=0 at a rising edge, the following SHALL apply regardless of state or stage (including mid-instruction and in HALT): pc=RESET_PC, stage=0, stage_onehot=1, retire=0, instr_count=0, halted=0, addr_fault=0, state RUN.
REQ-038 Reset SHALL take priority over stall and all control inputs.
REQ-039 The first stage advance SHALL occur on the first rising edge with reset=1.

Verification (PC_WIDTH=4, PROG_DEPTH=9, NUM_STAGES=5, RESET_PC=0)
REQ-040 Sequential run: release reset, no control inputs, 50 cycles.
  - Expected: pc follows 0,1,..8,0,1; each value lasts 5 cycles.
  - Expected: stage cycles 0..4; retire pulses every 5th cycle; instr_count=10.
REQ-041 Branch: at pc=3 on the advance edge, branch=1, zero=1, offset=2.
  - Expected: next pc=6.
  - Repeat with zero=0 -> next pc=4; with offset=-4 (4'b1100) -> next pc=0.
REQ-042 Jump with conflict: jump=1, jump_target=7, branch=1, zero=1 together.
  - Expected: next pc=7 (jump wins).
  - Then jump_target=12 -> halted=1, addr_fault=1, pc=7, stage_onehot=0.
REQ-043 Stall: assert stall for 3 cycles at stage 2.
  - Expected: stage stays 2 for 4 cycles total, then resumes.
  - Expected: stall asserted at stage 4 delays retire by the stall length.
REQ-044 Halt/reset: end_program=1 at pc=5.
  - Expected: retire pulses, halted=1, pc stays 5, and 20 further cycles change nothing.
  - Then reset=0 for 1 cycle at stage 3 of a running instruction -> all REQ-037 values next cycle.
REQ-045 Saturation: with CNT_WIDTH=3, run 10 instructions.
  - Expected: instr_count stops at 7 while retire keeps pulsing.
